inst_seq: RTL
=============

Name: inst_seq

Overview:
- Instruction sequencer directly upstream of the PE data memory.
- Buffers a short program loaded over a stream port, then replays it for a programmable number of loops, one instruction per cycle.
- Generates inst_v/inst, rden and wben for the data memory, with rden/wben timed to the memory read latency and the ALU write-back pipeline.
- Instruction format (shared): [31:24] opcode, [23:16] src2, [15:8] src1, [7:0] dst.

Parameters:
- IM_ADDR_WIDTH, 6, log2 of program buffer depth (64 instructions).
- RD_LAT, 1, cycles from inst_v to rden.
- WB_LAT, 5, cycles from inst_v to wben; must be > RD_LAT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- prog_clr  in  1  clears program length and overflow (IDLE only)
- inst_in_v  in  1  program load strobe
- inst_in  in  `INST_WIDTH  program word
- exec_start  in  1  start pulse (IDLE only)
- loop_num  in  8  loop count latched at start; 0 is treated as 1
- inst_v  out  1  instruction valid to data memory
- inst  out  `INST_WIDTH  instruction to data memory
- rden  out  1  data memory read enable
- wben  out  1  data memory write-back enable
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse
- prog_len  out  IM_ADDR_WIDTH+1  number of stored instructions
- overflow  out  1  sticky; load attempted while buffer full

Behaviour:
- Reset: every output 0, FSM IDLE, pc/loop/len 0, all delay-line stages 0. rst mid-RUN aborts immediately; no wben may be issued after rst deasserts.
- Buffer: synchronous-read RAM, 2**IM_ADDR_WIDTH x `INST_WIDTH.
- Load (IDLE only): inst_in_v writes buf[prog_len] and increments prog_len.
  - At prog_len == depth the word is dropped and overflow is set.
  - inst_in_v outside IDLE is ignored; it does not set overflow.
  - prog_clr and inst_in_v in the same cycle: clear wins.
- FSM states IDLE, RUN, DRAIN.
  - IDLE -> RUN: on exec_start with prog_len > 0. Latch loop_num (0 -> 1), pc = 0.
  - exec_start with prog_len == 0: stay IDLE, pulse done next cycle.
  - exec_start outside IDLE: ignored.
- RUN:
  - Each cycle read buf[pc]. The registered result drives inst, and inst_v = 1 in the following cycle; one instruction per cycle, no bubbles.
  - pc wraps from prog_len-1 to 0 and decrements the loop counter.
  - After the last read of the last loop -> DRAIN.
- DRAIN: stays until the last issued instruction's wben slot has passed (WB_LAT cycles after its inst_v), then -> IDLE with done = 1 for one cycle.
- inst outside an inst_v cycle: holds its last value.
- Delay lines: shift registers of length RD_LAT and WB_LAT, fed by issue_nop_free = inst_v && inst[31:24] != 8'h00.
  - rden = stage RD_LAT; wben = stage WB_LAT.
  - Opcode 8'h00 is NOP: inst_v still asserts, but produces no rden or wben.
- Timing at defaults: inst_v in cycle t -> rden at t+1, wben at t+5. This lines up with the memory's 4-deep dst-address delay plus registered write enable.
- busy = (state != IDLE). done never coincides with busy.
- Throughput: total inst_v count = prog_len × loops exactly.

Decomposition:
- Shared parameters.vh holds `INST_WIDTH, the opcode field positions, the NOP opcode value, and default RD_LAT/WB_LAT.
- One sub-module is natural: inst_seq_dly, a parameterised single-bit shift register with async clear, instantiated twice (RD_LAT, WB_LAT).
- The buffer is inferred inline with ram_style="distributed" or "block".

Test Plan:
- Load 3 words (0x01030201, 0x02060504, 0x00000000), loop_num=1, start.
  - inst_v exactly cycles t..t+2 with those words in order.
  - rden at t+1, t+2 only; wben at t+5, t+6 only.
  - done at t+8 (last wben slot t+7 passes, DRAIN exits), busy low on that cycle.
- Same program, loop_num=0 vs 3: 3 vs 9 contiguous inst_v cycles. Sequence wraps buf[2] -> buf[0] with no gap.
- Load 65 words with IM_ADDR_WIDTH=6: prog_len=64, overflow=1.
  - Word 65 absent on replay.
  - prog_clr then gives prog_len=0, overflow=0.
- exec_start with prog_len=0: done pulses next cycle, no inst_v.
  - exec_start and inst_in_v during RUN: no effect on sequence or prog_len.
- Assert rst two cycles after start of a 4-word run.
  - All outputs 0 asynchronously; no rden/wben in the 10 cycles after release.
  - Buffer reloadable and runnable afterward.

Source files
------------

// File: rtl/inst_seq_pkg.sv
// -----------------------------------------------------------------------------
// inst_seq_pkg
// Shared definitions for the PE instruction sequencer:
//   - instruction word width and opcode field position
//   - the NOP opcode value
//   - default buffer depth and read / write-back latencies
//   - sequencer state encoding
//   - helper that says whether an instruction touches the data memory
// -----------------------------------------------------------------------------
package inst_seq_pkg;

    localparam int INST_WIDTH = 32;

    // Instruction layout: [31:24] opcode, [23:16] src2, [15:8] src1, [7:0] dst
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    localparam int DEF_IM_ADDR_WIDTH = 6;
    localparam int DEF_RD_LAT        = 1;
    localparam int DEF_WB_LAT        = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } seq_state_t;

    // A NOP still occupies an issue slot but never reads or writes memory.
    function automatic logic is_active_op(input logic [INST_WIDTH-1:0] word);
        return word[OPC_MSB:OPC_LSB] != NOP_OPCODE;
    endfunction

endpackage

// File: rtl/inst_seq_dly.sv
// -----------------------------------------------------------------------------
// inst_seq_dly
// Single-bit shift register used to time memory strobes relative to inst_v.
//   clk   in   clock
//   rst   in   asynchronous active-high clear of every stage
//   din   in   bit entering stage 1
//   dout  out  bit after DEPTH clock edges
// -----------------------------------------------------------------------------
module inst_seq_dly #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    // A one-stage line cannot use the concatenation form (it would slice
    // below bit 0), so it gets its own branch.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages <= {stages[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/inst_seq.sv
// -----------------------------------------------------------------------------
// inst_seq
// Instruction sequencer in front of the PE data memory. A program is streamed
// into a small buffer while idle, then replayed loop_num times at one
// instruction per cycle. rden / wben follow each non-NOP instruction after
// RD_LAT / WB_LAT cycles to match the memory read and ALU write-back pipes.
//   clk, rst    clock, asynchronous active-high reset
//   prog_clr    clear program length and overflow (idle only)
//   inst_in_v   load strobe for inst_in (idle only)
//   inst_in     program word
//   exec_start  start pulse (idle only)
//   loop_num    loop count captured at start, 0 means 1
//   inst_v      instruction valid to data memory
//   inst        instruction to data memory, holds when inst_v is low
//   rden        data memory read enable
//   wben        data memory write-back enable
//   busy        running or draining
//   done        one-cycle completion pulse
//   prog_len    number of stored instructions
//   overflow    sticky: a load was attempted with the buffer full
// -----------------------------------------------------------------------------
module inst_seq
    import inst_seq_pkg::*;
#(
    parameter int IM_ADDR_WIDTH = DEF_IM_ADDR_WIDTH,
    parameter int RD_LAT        = DEF_RD_LAT,
    parameter int WB_LAT        = DEF_WB_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prog_clr,
    input  logic                    inst_in_v,
    input  logic [INST_WIDTH-1:0]   inst_in,
    input  logic                    exec_start,
    input  logic [7:0]              loop_num,
    output logic                    inst_v,
    output logic [INST_WIDTH-1:0]   inst,
    output logic                    rden,
    output logic                    wben,
    output logic                    busy,
    output logic                    done,
    output logic [IM_ADDR_WIDTH:0]  prog_len,
    output logic                    overflow
);

    localparam int                 DEPTH      = 1 << IM_ADDR_WIDTH;
    localparam logic [IM_ADDR_WIDTH:0] FULL_LEN = (IM_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [7:0]         DRAIN_LAST = 8'(WB_LAT);

    seq_state_t               state;
    seq_state_t               next_state;
    logic                     done_next;
    logic [IM_ADDR_WIDTH-1:0] pc;
    logic [7:0]               loops_left;
    logic [7:0]               drain_cnt;
    logic                     start_ok;
    logic                     load_en;
    logic                     buf_we;
    logic                     wrap;
    logic                     last_read;
    logic                     issue_nop_free;

    (* ram_style = "distributed" *)
    logic [INST_WIDTH-1:0] prog_mem [DEPTH];

    // A start that is accepted owns the cycle: loads and clears are only
    // honoured while the sequencer stays idle, so prog_len is stable for the
    // whole run.
    assign start_ok  = (state == ST_IDLE) && exec_start && (prog_len != '0);
    assign load_en   = (state == ST_IDLE) && !start_ok;
    assign buf_we    = load_en && !prog_clr && inst_in_v && (prog_len != FULL_LEN);
    assign wrap      = ({1'b0, pc} == (prog_len - 1'b1));
    assign last_read = wrap && (loops_left == 8'd1);
    assign busy      = (state != ST_IDLE);

    assign issue_nop_free = inst_v && is_active_op(inst);

    // Next-state logic. DRAIN lasts WB_LAT+1 cycles starting on the cycle
    // of the final inst_v, so it ends right after that instruction's wben
    // slot and done lands on the first idle cycle.
    always_comb begin
        next_state = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (exec_start) begin
                    if (prog_len != '0) begin
                        next_state = ST_RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (last_read) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= done_next;
        end
    end

    // Program counter, loop counter and drain timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            loops_left <= '0;
            drain_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        pc         <= '0;
                        loops_left <= (loop_num == 8'd0) ? 8'd1 : loop_num;
                    end
                    drain_cnt <= '0;
                end
                ST_RUN: begin
                    if (wrap) begin
                        pc         <= '0;
                        loops_left <= loops_left - 8'd1;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                    drain_cnt <= '0;
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 8'd1;
                end
                default: begin
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    // Synchronous buffer read. The read register is the inst output itself,
    // so inst_v trails the RUN cycle that issued the read by one cycle and
    // inst simply keeps its value when nothing is read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_v <= 1'b0;
            inst   <= '0;
        end else begin
            inst_v <= (state == ST_RUN);
            if (state == ST_RUN) begin
                inst <= prog_mem[pc];
            end
        end
    end

    // Program length and overflow bookkeeping; clear beats a same-cycle load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_len <= '0;
            overflow <= 1'b0;
        end else if (load_en) begin
            if (prog_clr) begin
                prog_len <= '0;
                overflow <= 1'b0;
            end else if (inst_in_v) begin
                if (prog_len == FULL_LEN) begin
                    overflow <= 1'b1;
                end else begin
                    prog_len <= prog_len + 1'b1;
                end
            end
        end
    end

    // Buffer storage has no reset; prog_len decides what is valid.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            prog_mem[prog_len[IM_ADDR_WIDTH-1:0]] <= inst_in;
        end
    end

    inst_seq_dly #(.DEPTH(RD_LAT)) u_rd_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (issue_nop_free),
        .dout (rden)
    );

    inst_seq_dly #(.DEPTH(WB_LAT)) u_wb_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (issue_nop_free),
        .dout (wben)
    );

endmodule
